// File: rtl/adder_multi_pipe.sv
// Pipelined N-operand modular adder: a balanced tree of 2-input adders with
// a register stage after every level. It returns the exact sum split into {o_carry, o_summ}.
module adder_multi_pipe #(
  parameter int WIDTH = 32,
  parameter int N_OPS = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [N_OPS*WIDTH-1:0]   i_ops,
  input  logic                     i_carry,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_summ,
  output logic [$clog2(N_OPS)-1:0] o_carry
);

  localparam int LEVELS = $clog2(N_OPS);
  localparam int CW     = $clog2(N_OPS);
  localparam int NW     = WIDTH + CW;
  localparam int LAST   = LEVELS - 1;

  // Number of nodes entering tree level k: ceil(N_OPS / 2^k).
  function automatic int node_cnt(input int k);
    return (N_OPS + (1 << k) - 1) >> k;
  endfunction

  if (N_OPS < 2 || N_OPS > 16) begin : g_param_check
    $error("adder_multi_pipe: N_OPS=%0d outside legal range 2..16", N_OPS);
  end

  genvar gi, gj;
  for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int N_IN  = node_cnt(gi);
    localparam int N_OUT = node_cnt(gi + 1);

    logic [NW-1:0] w_in [N_IN];
    logic          w_vin;
    logic          r_valid;

    if (gi == 0) begin : g_src
      for (gj = 0; gj < N_IN; gj++) begin : g_op
        assign w_in[gj] = {{CW{1'b0}}, i_ops[gj*WIDTH +: WIDTH]};
      end
      assign w_vin = i_valid;
    end else begin : g_src
      for (gj = 0; gj < N_IN; gj++) begin : g_op
        assign w_in[gj] = g_lvl[gi-1].g_node[gj].r_sum;
      end
      assign w_vin = g_lvl[gi-1].r_valid;
    end

    for (gj = 0; gj < N_OUT; gj++) begin : g_node
      logic [NW-1:0] w_sum;
      logic [NW-1:0] r_sum;

      if (2*gj + 1 < N_IN) begin : g_add
        // The carry-in rides along with the very first pair.
        if (gi == 0 && gj == 0) begin : g_cin
          assign w_sum = w_in[0] + w_in[1] + NW'(i_carry);
        end else begin : g_pair
          assign w_sum = w_in[2*gj] + w_in[2*gj+1];
        end
      end else begin : g_pass
        assign w_sum = w_in[2*gj];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst)
          r_sum <= '0;
        else if (i_en)
          r_sum <= w_sum;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst)
        r_valid <= 1'b0;
      else if (i_en)
        r_valid <= w_vin;
    end
  end

  assign o_valid           = g_lvl[LAST].r_valid;
  assign {o_carry, o_summ} = g_lvl[LAST].g_node[0].r_sum;

endmodule

// File: tb/tb_adder_multi_pipe.sv
// Randomised and directed bench for adder_multi_pipe (N_OPS = 5, 2 and 3),
// checked against a delay-line reference model that counts enabled edges.
module tb_adder_multi_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;

  logic         valid5 = 1'b0;
  logic [159:0] ops5   = '0;
  logic         carry5 = 1'b0;
  logic         ov5;
  logic [31:0]  os5;
  logic [2:0]   oc5;

  logic         valid2 = 1'b0;
  logic [63:0]  ops2   = '0;
  logic         ov2;
  logic [31:0]  os2;
  logic [0:0]   oc2;

  logic         valid3 = 1'b0;
  logic [95:0]  ops3   = '0;
  logic         ov3;
  logic [31:0]  os3;
  logic [1:0]   oc3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        v;
    logic [34:0] s;
  } ent_t;

  ent_t        pipe5[$];
  logic        exp_v5;
  logic [34:0] exp_s5;

  always #5 clk = ~clk;

  adder_multi_pipe #(.WIDTH(32), .N_OPS(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid5), .i_ops(ops5),
    .i_carry(carry5), .o_valid(ov5), .o_summ(os5), .o_carry(oc5)
  );

  adder_multi_pipe #(.WIDTH(32), .N_OPS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid2), .i_ops(ops2),
    .i_carry(1'b0), .o_valid(ov2), .o_summ(os2), .o_carry(oc2)
  );

  adder_multi_pipe #(.WIDTH(32), .N_OPS(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid3), .i_ops(ops3),
    .i_carry(1'b0), .o_valid(ov3), .o_summ(os3), .o_carry(oc3)
  );

  // Exact sum of five 32-bit operands plus carry, in plain integer arithmetic.
  function automatic logic [34:0] ref_sum5(input logic [159:0] ops, input logic c);
    longint unsigned acc;
    acc = 64'(c);
    for (int j = 0; j < 5; j++) acc += 64'(ops[j*32 +: 32]);
    return acc[34:0];
  endfunction

  function automatic logic [159:0] rand_ops5();
    logic [159:0] r;
    for (int j = 0; j < 5; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive dut5 inputs, advance the model, sample #1 after the edge.
  task automatic step5(input logic r, input logic e, input logic v,
                       input logic [159:0] ops, input logic c);
    ent_t ent;
    rst = r; en = e; valid5 = v; ops5 = ops; carry5 = c;
    @(posedge clk);
    #1;
    if (r) begin
      pipe5.delete();
      for (int k = 0; k < 3; k++) pipe5.push_back('0);
    end else if (e) begin
      ent.v = v;
      ent.s = ref_sum5(ops, c);
      pipe5.push_front(ent);
      void'(pipe5.pop_back());
    end
    exp_v5 = pipe5[2].v;
    exp_s5 = pipe5[2].s;
  endtask

  task automatic test_reset();
    step5(1'b1, 1'b1, 1'b1, rand_ops5(), 1'b1);
    step5(1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if (ov5 !== 1'b0 || os5 !== 32'h0 || oc5 !== 3'd0) begin
      n_err++;
      $display("FAIL reset5: got v=%b s=%h c=%0d want v=0 s=0 c=0", ov5, os5, oc5);
    end
    n_cmp++;
    if (ov2 !== 1'b0 || ov3 !== 1'b0 || os2 !== 32'h0 || os3 !== 32'h0) begin
      n_err++;
      $display("FAIL reset23: got v2=%b v3=%b s2=%h s3=%h want all 0", ov2, ov3, os2, os3);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic();
    logic [159:0] ops;
    ops = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    step5(1'b0, 1'b1, 1'b1, ops, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      n_cmp++;
      if (ov5 !== 1'b0) begin
        n_err++;
        $display("FAIL basic_early_valid: edge %0d got %b want 0", i, ov5);
      end
      step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    end
    n_cmp++;
    if (ov5 !== 1'b1 || os5 !== 32'h0000000F || oc5 !== 3'd0) begin
      n_err++;
      $display("FAIL basic_result: got v=%b s=%h c=%0d want v=1 s=0000000f c=0", ov5, os5, oc5);
    end
    $display("basic: 1+2+3+4+5 -> v=%b s=%h c=%0d", ov5, os5, oc5);
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (ov5 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_one_cycle: got v=%b want 0", ov5);
    end
  endtask

  task automatic test_max();
    step5(1'b0, 1'b1, 1'b1, {160{1'b1}}, 1'b1);
    step5(1'b0, 1'b1, 1'b1, {160{1'b1}}, 1'b0);
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (ov5 !== 1'b1 || os5 !== 32'hFFFFFFFC || oc5 !== 3'd4) begin
      n_err++;
      $display("FAIL max_carry1: got v=%b s=%h c=%0d want v=1 s=fffffffc c=4", ov5, os5, oc5);
    end
    $display("max carry1: s=%h c=%0d", os5, oc5);
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (ov5 !== 1'b1 || os5 !== 32'hFFFFFFFB || oc5 !== 3'd4) begin
      n_err++;
      $display("FAIL max_carry0: got v=%b s=%h c=%0d want v=1 s=fffffffb c=4", ov5, os5, oc5);
    end
    $display("max carry0: s=%h c=%0d", os5, oc5);
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) step5(1'b0, 1'b1, 1'b1, rand_ops5(), 1'($urandom_range(1)));
      else       step5(1'b0, 1'b1, 1'b0, rand_ops5(), 1'b0);
      n_cmp++;
      if (ov5 !== exp_v5 || (exp_v5 && {oc5, os5} !== exp_s5)) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got v=%b sum=%h want v=%b sum=%h", i, ov5, {oc5, os5}, exp_v5, exp_s5);
      end else if (exp_v5) begin
        $display("b2b cycle %0d: sum=%h", i, {oc5, os5});
      end
      if (ov5 === 1'b1) begin
        n_valid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    n_cmp++;
    if (n_valid != 8 || last - first + 1 != 8) begin
      n_err++;
      $display("FAIL b2b_count: got %0d valid over span %0d want 8 over 8", n_valid, last - first + 1);
    end
  endtask

  task automatic test_stall();
    logic        snap_v;
    logic [34:0] snap_s;
    int          n_res = 0;
    step5(1'b0, 1'b1, 1'b1, rand_ops5(), 1'b1);
    step5(1'b0, 1'b1, 1'b1, rand_ops5(), 1'b0);
    snap_v = ov5;
    snap_s = {oc5, os5};
    for (int i = 0; i < 4; i++) begin
      step5(1'b0, 1'b0, 1'b1, rand_ops5(), 1'b1);
      n_cmp++;
      if (ov5 !== snap_v || {oc5, os5} !== snap_s) begin
        n_err++;
        $display("FAIL stall_frozen%0d: got v=%b sum=%h want v=%b sum=%h", i, ov5, {oc5, os5}, snap_v, snap_s);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
      n_cmp++;
      if (ov5 !== exp_v5 || (exp_v5 && {oc5, os5} !== exp_s5)) begin
        n_err++;
        $display("FAIL stall_drain%0d: got v=%b sum=%h want v=%b sum=%h", i, ov5, {oc5, os5}, exp_v5, exp_s5);
      end else if (exp_v5) begin
        $display("stall drain %0d: sum=%h", i, {oc5, os5});
      end
      if (ov5 === 1'b1) n_res++;
    end
    n_cmp++;
    if (n_res != 2) begin
      n_err++;
      $display("FAIL stall_count: got %0d results want 2", n_res);
    end
  endtask

  task automatic test_reset_midflight();
    step5(1'b0, 1'b1, 1'b1, rand_ops5(), 1'b0);
    step5(1'b1, 1'b1, 1'b1, rand_ops5(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
      n_cmp++;
      if (ov5 !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_valid%0d: got %b want 0", i, ov5);
      end
    end
    $display("reset mid-flight: no stale result");
  endtask

  task automatic test_n_ops2();
    ops2 = {32'h00000001, 32'hFFFFFFFF};
    valid2 = 1'b1;
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    valid2 = 1'b0;
    n_cmp++;
    if (ov2 !== 1'b1 || os2 !== 32'h0 || oc2 !== 1'b1) begin
      n_err++;
      $display("FAIL nops2: got v=%b s=%h c=%0d want v=1 s=00000000 c=1", ov2, os2, oc2);
    end
    $display("n_ops2: s=%h c=%0d", os2, oc2);
  endtask

  task automatic test_n_ops3();
    ops3 = {3{32'h80000000}};
    valid3 = 1'b1;
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    valid3 = 1'b0;
    n_cmp++;
    if (ov3 !== 1'b0) begin
      n_err++;
      $display("FAIL nops3_early: got v=%b want 0", ov3);
    end
    step5(1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (ov3 !== 1'b1 || os3 !== 32'h80000000 || oc3 !== 2'd1) begin
      n_err++;
      $display("FAIL nops3: got v=%b s=%h c=%0d want v=1 s=80000000 c=1", ov3, os3, oc3);
    end
    $display("n_ops3: s=%h c=%0d", os3, oc3);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) pipe5.push_back('0);
    exp_v5 = 1'b0;
    exp_s5 = '0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_n_ops2();
    test_n_ops3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_multi_pipe.md
Name: adder_multi_pipe

Overview:
- Pipelined N-operand modular adder, the parametrised successor to the single-cycle 2-input 32-bit adder wrapper.
- Sums N_OPS operands plus a carry-in through a balanced binary tree of 2-input adders, with a register after every tree level.
- Produces the modulo-2^WIDTH sum and the overflow count.
- Used in the SHA-256 round datapath for T1 = h + Σ1 + Ch + K + W (5 operands) and T1 + T2, so those sums no longer form one long combinational chain.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- N_OPS, 5, number of operands; legal range 2..16.
- LEVELS, $clog2(N_OPS), derived (localparam): tree depth, which equals the pipeline latency in enabled cycles.
- CW, $clog2(N_OPS), derived (localparam): carry-out width, enough to hold N_OPS-1.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  pipeline advance; 0 freezes every stage register.
- i_valid  input  1  operand set on i_ops/i_carry is valid this cycle.
- i_ops  input  N_OPS*WIDTH  packed operands; operand j = i_ops[j*WIDTH +: WIDTH].
- i_carry  input  1  carry-in, added at tree level 0 together with operand 0.
- o_valid  output  1  o_summ/o_carry hold a result.
- o_summ  output  WIDTH  sum modulo 2^WIDTH.
- o_carry  output  CW  floor(total sum / 2^WIDTH).

Behaviour:
- Reset: on a rising edge with i_rst=1, every stage valid bit, o_valid, o_summ and o_carry go to 0. Reset has priority over i_en. In-flight operand sets are discarded, not completed.
- Arithmetic:
  - All internal nodes are WIDTH+CW bits wide, operands zero-extended. No intermediate truncation; the full sum is exact.
  - Output {o_carry, o_summ} = i_carry + sum of all operands.
  - Maximum sum N_OPS*(2^WIDTH-1)+1 always fits in WIDTH+CW bits.
- Tree:
  - Level k pairs adjacent nodes (0+1, 2+3, ...). An odd leftover node is passed through unchanged to the next level.
  - Each level's results are registered, along with a valid bit.
  - Level 0 node 0 is op0 + op1 + i_carry.
- Latency: result is available exactly LEVELS rising edges with i_en=1 after it is presented (3 for N_OPS=5, 1 for N_OPS=2). Edges with i_en=0 do not count.
- Throughput: one operand set per enabled cycle. Back-to-back sets emerge in order with no bubbles.
- i_en=0:
  - All data and valid registers hold, so o_valid/o_summ/o_carry are stable.
  - Inputs presented while i_en=0 are ignored; no capture.
- i_valid=0 with i_en=1: a bubble (valid=0) advances. Data registers may load don't-care values, but o_summ/o_carry are checked only when o_valid=1.
- No backpressure output: the consumer controls flow through i_en only.
- Simultaneous i_rst=1 and i_valid=1: reset wins and the set is dropped.
- Parameter check: N_OPS<2 or N_OPS>16 triggers a $error at elaboration.

Test Plan:
- Reset, then N_OPS=5, ops 1,2,3,4,5, carry 0 -> o_valid=1 after 3 enabled edges, o_summ=0x0000000F, o_carry=0; o_valid=1 for one cycle only.
- N_OPS=5, all ops 0xFFFFFFFF, carry 1 -> o_summ=0xFFFFFFFC, o_carry=4. Same ops with carry 0 -> 0xFFFFFFFB, o_carry=4.
- Back-to-back, 8 consecutive random sets with i_valid=1 and i_en=1 -> 8 consecutive o_valid cycles, each result matching a reference model, in order.
- Stall: i_en=0 for 4 cycles while 2 sets are in flight -> outputs frozen during the stall; both results appear afterwards, with latency counted in enabled edges only; inputs during the stall are not captured.
- Reset mid-flight: assert i_rst one cycle after presenting a set -> o_valid stays 0, with no stale result after reset is released.
- N_OPS=2: ops 0xFFFFFFFF + 0x00000001, carry 0 -> after 1 enabled edge o_summ=0x00000000, o_carry=1. N_OPS=3 (odd pass-through) with ops 0x80000000 x3 -> o_summ=0x80000000, o_carry=1, after 2 edges.
